// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter sharing one ALU between a load
//               address-generation path and an R-type path over 4-phase
//               req/ack handshakes, with sticky opcode and timeout errors.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_1,
    input  logic       req_2,
    input  logic [6:0] opcode_1,
    input  logic [6:0] opcode_2,
    output logic       ack_out_1,
    output logic       ack_out_2,
    output logic       req_out,
    input  logic       ack_in,
    output logic       alu_sel,
    output logic       busy,
    output logic       err_opcode,
    output logic       err_timeout,
    input  logic       clr_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ALU_REQ = 2'd1;
    localparam logic [1:0] c_REQ_ACK = 2'd2;
    localparam logic [1:0] c_ALU_REL = 2'd3;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_M1 = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_req1_sync;
    logic [SYNC_STAGES-1:0] r_req2_sync;
    logic [SYNC_STAGES-1:0] r_ack_sync;

    logic [1:0]         r_state;
    logic               r_owner;       // 0 = requester 1, 1 = requester 2
    logic               r_bypass;
    logic               r_last_was_2;
    logic               r_req_out;
    logic               r_ack_out_1;
    logic               r_ack_out_2;
    logic               r_alu_sel;
    logic               r_err_opcode;
    logic               r_err_timeout;
    logic [c_CNT_W-1:0] r_cnt;

    logic       w_req1_s;
    logic       w_req2_s;
    logic       w_ack_s;
    logic       w_elig1;
    logic       w_elig2;
    logic       w_pick2;
    logic       w_op_ok;
    logic       w_owner_req_s;
    logic       w_waiting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req1_sync <= '0;
            r_req2_sync <= '0;
            r_ack_sync  <= '0;
        end else begin
            r_req1_sync <= {r_req1_sync[SYNC_STAGES-2:0], req_1};
            r_req2_sync <= {r_req2_sync[SYNC_STAGES-2:0], req_2};
            r_ack_sync  <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign w_req1_s = r_req1_sync[SYNC_STAGES-1];
    assign w_req2_s = r_req2_sync[SYNC_STAGES-1];
    assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];

    always_comb begin
        w_elig1       = w_req1_s && !r_ack_out_1;
        w_elig2       = w_req2_s && !r_ack_out_2;
        // On a tie, the requester that did not win last time gets the grant.
        w_pick2       = w_elig2 && (!w_elig1 || !r_last_was_2);
        w_op_ok       = w_pick2 ? (opcode_2 == c_OP_RTYPE) : (opcode_1 == c_OP_LOAD);
        w_owner_req_s = r_owner ? w_req2_s : w_req1_s;
        w_waiting     = ((r_state == c_ALU_REQ) && !w_ack_s) ||
                        ((r_state == c_ALU_REL) &&  w_ack_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_owner       <= 1'b0;
            r_bypass      <= 1'b0;
            r_last_was_2  <= 1'b1;
            r_req_out     <= 1'b0;
            r_ack_out_1   <= 1'b0;
            r_ack_out_2   <= 1'b0;
            r_alu_sel     <= 1'b0;
            r_err_opcode  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            // Clear first so that a set event later in this block wins.
            if (clr_err) begin
                r_err_opcode  <= 1'b0;
                r_err_timeout <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_elig1 || w_elig2) begin
                        r_owner      <= w_pick2;
                        r_last_was_2 <= w_pick2;
                        r_alu_sel    <= w_pick2;
                        if (w_op_ok) begin
                            r_bypass  <= 1'b0;
                            r_req_out <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= c_ALU_REQ;
                        end else begin
                            r_bypass     <= 1'b1;
                            r_err_opcode <= 1'b1;
                            if (w_pick2) r_ack_out_2 <= 1'b1;
                            else         r_ack_out_1 <= 1'b1;
                            r_state <= c_REQ_ACK;
                        end
                    end
                end
                c_ALU_REQ: begin
                    if (w_ack_s) begin
                        if (r_owner) r_ack_out_2 <= 1'b1;
                        else         r_ack_out_1 <= 1'b1;
                        r_state <= c_REQ_ACK;
                    end
                end
                c_REQ_ACK: begin
                    if (!w_owner_req_s) begin
                        if (r_bypass) begin
                            if (r_owner) r_ack_out_2 <= 1'b0;
                            else         r_ack_out_1 <= 1'b0;
                            r_state <= c_IDLE;
                        end else begin
                            r_req_out <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= c_ALU_REL;
                        end
                    end
                end
                c_ALU_REL: begin
                    if (!w_ack_s) begin
                        if (r_owner) r_ack_out_2 <= 1'b0;
                        else         r_ack_out_1 <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            // Timeout only flags the stall; the handshake keeps waiting.
            if (w_waiting && (r_cnt != c_TIMEOUT)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (r_cnt == c_TIMEOUT_M1) r_err_timeout <= 1'b1;
            end
        end
    end

    assign ack_out_1   = r_ack_out_1;
    assign ack_out_2   = r_ack_out_2;
    assign req_out     = r_req_out;
    assign alu_sel     = r_alu_sel;
    assign busy        = (r_state != c_IDLE);
    assign err_opcode  = r_err_opcode;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter: vector table,
//               directed corner sequences and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int SYNC    = 2;
    localparam int TMO     = 8;
    localparam int BUDGET  = 200;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_1 = 1'b0;
    logic       req_2 = 1'b0;
    logic [6:0] opcode_1 = '0;
    logic [6:0] opcode_2 = '0;
    logic       ack_in = 1'b0;
    logic       clr_err = 1'b0;
    logic       ack_out_1, ack_out_2, req_out, alu_sel, busy, err_opcode, err_timeout;

    alu_share_arbiter #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_1(req_1), .req_2(req_2),
        .opcode_1(opcode_1), .opcode_2(opcode_2),
        .ack_out_1(ack_out_1), .ack_out_2(ack_out_2), .req_out(req_out),
        .ack_in(ack_in), .alu_sel(alu_sel), .busy(busy),
        .err_opcode(err_opcode), .err_timeout(err_timeout), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   alu_auto = 1'b0;
    int   alu_max_delay = 0;
    int   order[$];
    int   req_out_rises = 0;
    bit   sel_bad = 1'b0;
    bit   overlap_bad = 1'b0;

    typedef struct {
        int         k;
        logic [6:0] op;
        bit         exp_ok;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return req_out;
            1:       return ack_out_1;
            2:       return ack_out_2;
            default: return busy;
        endcase
    endfunction

    function automatic logic [6:0] good_op(input int k);
        return (k == 1) ? OP_LOAD : OP_RTYPE;
    endfunction

    task automatic wait_sig(input int which, input logic val, input string name, output int cycles);
        cycles = 0;
        while (sig(which) !== val && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        if (sig(which) !== val) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timed out after %0d cycles waiting for level %0d", name, cycles, val);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [6:0] op);
        if (k == 1) begin opcode_1 = op; req_1 = v; end
        else        begin opcode_2 = op; req_2 = v; end
    endtask

    task automatic do_txn(input int k, input logic [6:0] op);
        int c;
        set_req(k, 1'b1, op);
        wait_sig(k, 1'b1, "ack_rise", c);
        order.push_back(k);
        set_req(k, 1'b0, op);
        wait_sig(k, 1'b0, "ack_fall", c);
    endtask

    task automatic requester_loop(input int k, input int n);
        for (int i = 0; i < n; i++) do_txn(k, good_op(k));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_1 = 1'b0; req_2 = 1'b0; ack_in = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // ALU model: follows req_out after a random number of cycles.
    initial forever begin
        @(negedge clk);
        if (alu_auto && ack_in !== req_out) begin
            repeat ($urandom_range(alu_max_delay, 0)) @(negedge clk);
            if (alu_auto) ack_in = req_out;
        end
    end

    // Protocol monitor: alu_sel stable under req_out, acks mutually exclusive.
    initial begin
        logic prev_req = 1'b0;
        logic sel_rise = 1'b0;
        forever begin
            @(negedge clk);
            if (req_out && prev_req && alu_sel !== sel_rise) sel_bad = 1'b1;
            if (req_out && !prev_req) begin
                sel_rise = alu_sel;
                req_out_rises++;
            end
            if (ack_out_1 && ack_out_2) overlap_bad = 1'b1;
            prev_req = req_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Randomized traffic scoreboard state
    logic [6:0] q_op1[$];
    logic [6:0] q_op2[$];
    bit         done1, done2;

    task automatic rand_requester(input int k, input int n);
        logic [6:0] op;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            op = ($urandom_range(3, 0) != 0) ? good_op(k) : 7'($urandom);
            if (k == 1) q_op1.push_back(op); else q_op2.push_back(op);
            do_txn(k, op);
        end
        if (k == 1) done1 = 1'b1; else done2 = 1'b1;
    endtask

    task automatic rand_checker();
        logic p1 = 1'b0, p2 = 1'b0;
        logic [6:0] op;
        bit ok;
        while (!(done1 && done2)) begin
            @(negedge clk);
            for (int k = 1; k <= 2; k++) begin
                if (sig(k) && !(k == 1 ? p1 : p2)) begin
                    if ((k == 1 ? q_op1.size() : q_op2.size()) == 0) begin
                        check("rand_unexpected_ack", 1, 0);
                    end else begin
                        op = (k == 1) ? q_op1.pop_front() : q_op2.pop_front();
                        ok = (op == good_op(k));
                        check("rand_alu_used", req_out, ok);
                        if (ok) check("rand_alu_sel", alu_sel, k - 1);
                        else    check("rand_err_opcode", err_opcode, 1);
                    end
                end
            end
            p1 = ack_out_1;
            p2 = ack_out_2;
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   c;
        int   rises0;
        int   exp_order[4];

        vecs[0] = '{k: 1, op: 7'b0000011, exp_ok: 1'b1};
        vecs[1] = '{k: 2, op: 7'b0110011, exp_ok: 1'b1};
        vecs[2] = '{k: 1, op: 7'b0110011, exp_ok: 1'b0};
        vecs[3] = '{k: 2, op: 7'b0000011, exp_ok: 1'b0};
        vecs[4] = '{k: 1, op: 7'b0010011, exp_ok: 1'b0};
        vecs[5] = '{k: 2, op: 7'b0110011, exp_ok: 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_out", req_out, 0);
        check("rst_ack_out_1", ack_out_1, 0);
        check("rst_ack_out_2", ack_out_2, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {err_opcode, err_timeout}, 0);
        apply_reset();

        // Single transactions from the vector table
        alu_auto = 1'b1;
        alu_max_delay = 0;
        for (int i = 0; i < 6; i++) begin
            rises0 = req_out_rises;
            set_req(vecs[i].k, 1'b1, vecs[i].op);
            if (vecs[i].exp_ok) begin
                wait_sig(0, 1'b1, "vec_req_out_rise", c);
                check("vec_req_latency", c, SYNC + 1);
                check("vec_alu_sel", alu_sel, vecs[i].k - 1);
                check("vec_busy", busy, 1);
                wait_sig(vecs[i].k, 1'b1, "vec_ack_rise", c);
            end else begin
                wait_sig(vecs[i].k, 1'b1, "vec_ack_rise", c);
                check("vec_bypass_latency", c, SYNC + 1);
                check("vec_bypass_req_out", req_out, 0);
                check("vec_err_opcode_set", err_opcode, 1);
            end
            set_req(vecs[i].k, 1'b0, vecs[i].op);
            wait_sig(vecs[i].k, 1'b0, "vec_ack_fall", c);
            check("vec_idle_busy", busy, 0);
            check("vec_alu_rises", req_out_rises - rises0, vecs[i].exp_ok);
            check("vec_err_opcode_hold", err_opcode, !vecs[i].exp_ok);
            pulse_clr();
            check("vec_err_opcode_clr", err_opcode, 0);
        end

        // Ties right after reset, then a second tie, then alternation
        apply_reset();
        order.delete();
        fork
            requester_loop(1, 1);
            requester_loop(2, 1);
        join
        check("tie1_count", order.size(), 2);
        check("tie1_first", order[0], 1);
        check("tie1_second", order[1], 2);
        repeat (3) @(negedge clk);
        order.delete();
        fork
            requester_loop(1, 1);
            requester_loop(2, 1);
        join
        check("tie2_first", order[0], 1);
        check("tie2_second", order[1], 2);
        repeat (3) @(negedge clk);
        order.delete();
        sel_bad = 1'b0;
        overlap_bad = 1'b0;
        fork
            requester_loop(1, 2);
            requester_loop(2, 2);
        join
        exp_order = '{1, 2, 1, 2};
        check("alt_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            check("alt_order", (i < order.size()) ? order[i] : 0, exp_order[i]);
        check("alt_sel_stable", sel_bad, 0);
        check("alt_ack_exclusive", overlap_bad, 0);
        check("alt_errs", {err_opcode, err_timeout}, 0);

        // Timeout: ALU stalls with ack_in low
        alu_auto = 1'b0;
        apply_reset();
        set_req(1, 1'b1, OP_LOAD);
        wait_sig(0, 1'b1, "tmo_req_out", c);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_yet", err_timeout, 0);
        @(negedge clk);
        check("tmo_set", err_timeout, 1);
        check("tmo_still_waiting", {req_out, ack_out_1}, 2'b10);
        ack_in = 1'b1;
        wait_sig(1, 1'b1, "tmo_ack_rise", c);
        set_req(1, 1'b0, OP_LOAD);
        wait_sig(0, 1'b0, "tmo_req_out_fall", c);
        ack_in = 1'b0;
        wait_sig(1, 1'b0, "tmo_ack_fall", c);
        check("tmo_sticky", err_timeout, 1);
        check("tmo_busy", busy, 0);
        pulse_clr();
        check("tmo_clr", err_timeout, 0);

        // Asynchronous reset in the middle of an ALU request
        apply_reset();
        set_req(2, 1'b1, OP_RTYPE);
        wait_sig(0, 1'b1, "rstmid_req_out", c);
        check("rstmid_sel_before", alu_sel, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_outputs", {req_out, ack_out_1, ack_out_2, alu_sel, busy, err_opcode, err_timeout}, 0);
        req_2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmid_idle", {busy, req_out}, 0);

        // Randomized traffic against the queue-based reference model
        apply_reset();
        alu_auto = 1'b1;
        alu_max_delay = 3;
        q_op1.delete();
        q_op2.delete();
        done1 = 1'b0;
        done2 = 1'b0;
        sel_bad = 1'b0;
        overlap_bad = 1'b0;
        fork
            rand_requester(1, 12);
            rand_requester(2, 12);
            rand_checker();
        join
        check("rand_q1_drained", q_op1.size(), 0);
        check("rand_q2_drained", q_op2.size(), 0);
        check("rand_no_timeout", err_timeout, 0);
        check("rand_sel_stable", sel_bad, 0);
        check("rand_ack_exclusive", overlap_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Clocked arbiter that shares one ALU between two 4-phase req/ack requesters:
  - requester 1: load address-generation path (I-type load, opcode 7'b0000011).
  - requester 2: R-type execute path (opcode 7'b0110011).
- Synchronizes the asynchronous handshake inputs, grants one requester at a time by round-robin, and drives the ALU-side handshake and operation select.
- Sits between the two issue paths and the shared ALU in the asynchronous execute stage.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (req_1, req_2, ack_in); legal values ≥ 2.
- TIMEOUT_CYCLES, 64, clk cycles allowed waiting on an ALU ack edge before err_timeout sets; legal values ≥ 1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_1  input  1  4-phase request, load path (asynchronous)
- req_2  input  1  4-phase request, R-type path (asynchronous)
- opcode_1  input  7  opcode from load path; stable while req_1 high
- opcode_2  input  7  opcode from R-type path; stable while req_2 high
- ack_out_1  output  1  4-phase acknowledge to load path
- ack_out_2  output  1  4-phase acknowledge to R-type path
- req_out  output  1  4-phase request to ALU
- ack_in  input  1  4-phase acknowledge from ALU (asynchronous)
- alu_sel  output  1  ALU operand/op select: 0 = load address add, 1 = R-type; valid while req_out high
- busy  output  1  high whenever state ≠ IDLE
- err_opcode  output  1  sticky: a granted requester presented the wrong opcode class
- err_timeout  output  1  sticky: ALU ack edge not seen within TIMEOUT_CYCLES
- clr_err  input  1  synchronous clear of both sticky error flags

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0 and all synchronizer flops 0.
  - State = IDLE, timeout counter = 0.
  - Round-robin pointer last = 2, so requester 1 wins the first tie.
- Synchronizers:
  - req_1, req_2 and ack_in each pass through SYNC_STAGES flops; suffix _s denotes the synchronized value.
  - All decisions use _s values.
  - All outputs are registered, with no combinational path from inputs to outputs.
- Requester k is eligible when req_k_s = 1 and ack_out_k = 0.
- IDLE:
  - One eligible requester: grant it.
  - Both eligible: grant the one ≠ last.
  - Grant updates last.
  - Opcode check:
    - Granted opcode matches its class: next edge req_out = 1, alu_sel = k−1, go ALU_REQ.
    - Opcode mismatch: err_opcode = 1, no ALU transaction (bypass), next edge ack_out_k = 1, go REQ_ACK.
- ALU_REQ: wait ack_in_s = 1, then next edge ack_out_k = 1, go REQ_ACK.
- REQ_ACK: wait req_k_s = 0, then:
  - Normal: next edge req_out = 0, go ALU_REL.
  - Bypass: next edge ack_out_k = 0, go IDLE.
- ALU_REL: wait ack_in_s = 0, then next edge ack_out_k = 0, go IDLE.
- alu_sel:
  - Holds its value from the grant edge until the next grant.
  - Never changes while req_out = 1.
- Minimum latency, req_k edge to ack_out_k edge: SYNC_STAGES + 1 cycles (bypass), plus ALU response time in the normal case.
- The other requester's req is ignored (left pending) until return to IDLE. Each completed transaction consumes one IDLE cycle.
- Timeout:
  - Counter clears on entry to ALU_REQ and ALU_REL and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES: err_timeout = 1, counter saturates, handshake keeps waiting (no abort).
- Error flags:
  - Sticky until clr_err = 1 (clears at the next edge) or reset.
  - A set event in the same cycle as clr_err takes priority: flag ends 1.
- Protocol errors by the requester (req dropping before ack, or while in ALU_REQ) are not checked. The FSM simply waits for the expected level.
- Reset mid-transaction returns to IDLE with all outputs 0. Requesters and ALU must also be reset.

Test Plan:
- Single load: req_1 = 1 with opcode_1 = 7'b0000011 → req_out rises SYNC_STAGES+1 cycles later with alu_sel = 0; ack_in = 1 → ack_out_1 = 1; req_1 = 0 → req_out = 0; ack_in = 0 → ack_out_1 = 0, busy = 0.
- Simultaneous requests: req_1 and req_2 rise on the same edge after reset → requester 1 served first (alu_sel = 0), then requester 2 (alu_sel = 1); on the next tie requester 1 is served first again (last = 2).
- Back-to-back alternation: both requesters re-request immediately after ack falls, for 4 transactions → grant order 1, 2, 1, 2; req_out never high for two owners at once; alu_sel stable throughout each req_out-high window.
- Bad opcode: req_2 = 1 with opcode_2 = 7'b0000011 → err_opcode = 1, req_out stays 0, ack_out_2 rises; req_2 = 0 → ack_out_2 = 0; clr_err pulse → err_opcode = 0.
- Timeout with TIMEOUT_CYCLES = 8: ALU holds ack_in = 0 after req_out = 1 → err_timeout = 1 after 8 cycles in ALU_REQ; ack_in then rises → transaction completes normally and err_timeout stays 1.
- Reset mid-op: assert rst_n = 0 while in ALU_REQ → all outputs 0 immediately (asynchronous); after release with no requests, state = IDLE and busy = 0.
